// File: rtl/uno_pkg.sv
// Shared UNO types and constants: 6-bit card encoding {color, value}, deck size,
// canonical deck ordering and the dealer's LFSR step.
package uno_pkg;

  typedef logic [5:0] card_t;

  localparam logic [3:0] SKIP    = 4'd10;
  localparam logic [3:0] REVERSE = 4'd11;
  localparam logic [3:0] DRAW2   = 4'd12;
  localparam logic [3:0] WILD    = 4'd13;
  localparam logic [3:0] WILD4   = 4'd14;

  localparam int unsigned DECK_SIZE = 108;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StShuffle,
    StReady
  } deal_state_t;

  // Colors 0..3 hold 25 cards each (0,1,1,...,12,12); then four Wild, four Wild Draw4.
  function automatic card_t canonical_card(input int unsigned n);
    int unsigned color;
    int unsigned value;
    if (n < 100) begin
      color = n / 25;
      value = ((n % 25) + 1) / 2;
      return {color[1:0], value[3:0]};
    end else if (n < 104) begin
      return {2'b00, WILD};
    end else begin
      return {2'b00, WILD4};
    end
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/uno_deck_dealer_if.sv
// Dealer <-> game controller signal bundle; master is the controller, slave the dealer.
interface uno_deck_dealer_if;
  import uno_pkg::*;

  logic       i_start;
  logic       i_draw;
  card_t      o_card;
  logic       o_card_valid;
  logic [6:0] o_remaining;
  logic       o_ready;
  logic       o_empty;

  modport master (
    output i_start, i_draw,
    input  o_card, o_card_valid, o_remaining, o_ready, o_empty
  );

  modport slave (
    input  i_start, i_draw,
    output o_card, o_card_valid, o_remaining, o_ready, o_empty
  );

endinterface

// File: rtl/uno_lfsr16.sv
// 16-bit Galois LFSR with synchronous reset-to-seed, load and advance controls.
module uno_lfsr16
  import uno_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  input  logic        i_adv,
  output logic [15:0] o_val
);

  logic [15:0] val_d, val_q;

  always_comb begin
    val_d = val_q;
    if (i_load) begin
      val_d = i_seed;
    end else if (i_adv) begin
      val_d = lfsr_next(val_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      val_q <= i_seed;
    end else begin
      val_q <= val_d;
    end
  end

  assign o_val = val_q;

endmodule

// File: rtl/uno_deck_dealer.sv
// UNO deck holder: reload, Fisher-Yates shuffle (one swap per cycle) and single-card deal.
// Define UNO_DECK_FREE_RUN_EN to let the LFSR run in every state instead of reseeding per start.
module uno_deck_dealer
  import uno_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input logic               i_clk,
  input logic               i_rst,
  uno_deck_dealer_if.slave  bus
);

  localparam logic [15:0] SeedEff = (SEED == 16'd0) ? DEFAULT_SEED : SEED;

  deal_state_t state_d, state_q;
  logic [6:0]  idx_d, idx_q;
  logic [6:0]  remaining_d, remaining_q;
  card_t       card_d, card_q;
  logic        valid_d, valid_q;
  logic        empty_d, empty_q;
  card_t       deck_d [DECK_SIZE];
  card_t       deck_q [DECK_SIZE];

  logic        lfsr_load, lfsr_adv;
  logic [15:0] lfsr_val;
  logic [22:0] prod;
  logic [6:0]  j;

`ifdef UNO_DECK_FREE_RUN_EN
  assign lfsr_load = 1'b0;
  assign lfsr_adv  = 1'b1;
`else
  assign lfsr_load = (state_q == StInit);
  assign lfsr_adv  = (state_q == StShuffle);
`endif

  uno_lfsr16 u_lfsr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (lfsr_load),
    .i_seed (SeedEff),
    .i_adv  (lfsr_adv),
    .o_val  (lfsr_val)
  );

  // Scaling the 16-bit random value by (i+1) and keeping the top bits maps it onto 0..i.
  assign prod = {7'd0, lfsr_val} * {16'd0, idx_q + 7'd1};
  assign j    = prod[22:16];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    remaining_d = remaining_q;
    card_d      = card_q;
    valid_d     = 1'b0;
    deck_d      = deck_q;
    unique case (state_q)
      StIdle: begin
        if (bus.i_start) state_d = StInit;
      end
      StInit: begin
        for (int unsigned i = 0; i < DECK_SIZE; i++) deck_d[i] = canonical_card(i);
        idx_d       = 7'd107;
        remaining_d = 7'd108;
        state_d     = StShuffle;
      end
      StShuffle: begin
        if (bus.i_start) begin
          state_d = StInit;
        end else begin
          deck_d[idx_q] = deck_q[j];
          deck_d[j]     = deck_q[idx_q];
          idx_d         = idx_q - 7'd1;
          if (idx_q == 7'd1) state_d = StReady;
        end
      end
      StReady: begin
        if (bus.i_start) begin
          state_d = StInit;
        end else if (bus.i_draw && (remaining_q != 7'd0)) begin
          card_d      = deck_q[remaining_q - 7'd1];
          valid_d     = 1'b1;
          remaining_d = remaining_q - 7'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    empty_d = (state_d == StReady) && (remaining_d == 7'd0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      idx_q       <= 7'd0;
      remaining_q <= 7'd0;
      card_q      <= '0;
      valid_q     <= 1'b0;
      empty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      remaining_q <= remaining_d;
      card_q      <= card_d;
      valid_q     <= valid_d;
      empty_q     <= empty_d;
    end
  end

  // Deck contents are meaningless until INIT, so the array carries no reset.
  always_ff @(posedge i_clk) begin
    deck_q <= deck_d;
  end

  assign bus.o_card       = card_q;
  assign bus.o_card_valid = valid_q;
  assign bus.o_remaining  = remaining_q;
  assign bus.o_ready      = (state_q == StReady);
  assign bus.o_empty      = empty_q;

endmodule
